// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port register memory.
// One access in flight at a time; read returns are bounded by a timeout.
module mem_access_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_0,
  output logic                  req_ready_1,
  input  logic                  req_wr_0,
  input  logic                  req_wr_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  rsp_valid_0,
  output logic                  rsp_valid_1,
  output logic [DATA_WIDTH-1:0] rsp_rdata_0,
  output logic [DATA_WIDTH-1:0] rsp_rdata_1,
  output logic                  rsp_err_0,
  output logic                  rsp_err_1,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] Data_in,
  output logic                  EN,
  output logic                  WR,
  input  logic [DATA_WIDTH-1:0] Data_out,
  input  logic                  valid_out
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            r_state;
  logic                  r_last;
  logic                  r_owner;
  logic                  r_wr;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_en;
  logic                  r_wr_out;
  logic                  r_rsp_valid_0;
  logic                  r_rsp_valid_1;
  logic                  r_rsp_err_0;
  logic                  r_rsp_err_1;
  logic [DATA_WIDTH-1:0] r_rsp_rdata_0;
  logic [DATA_WIDTH-1:0] r_rsp_rdata_1;

  logic [1:0]            w_state_nx;
  logic                  w_last_nx;
  logic                  w_owner_nx;
  logic                  w_wr_nx;
  logic [CNT_W-1:0]      w_cnt_nx;
  logic [ADDR_WIDTH-1:0] w_addr_nx;
  logic [DATA_WIDTH-1:0] w_wdata_nx;
  logic                  w_en_nx;
  logic                  w_wr_out_nx;
  logic                  w_rsp_fire;
  logic                  w_rsp_err;
  logic [DATA_WIDTH-1:0] w_rsp_rdata;

  logic                  w_idle;
  logic                  w_gnt_0;
  logic                  w_gnt_1;

  // Tie goes to the requester that was not granted last.
  assign w_idle  = (r_state == S_IDLE) && !rst;
  assign w_gnt_0 = req_valid_0 && (!req_valid_1 || r_last);
  assign w_gnt_1 = req_valid_1 && (!req_valid_0 || !r_last);

  assign req_ready_0 = w_idle && w_gnt_0;
  assign req_ready_1 = w_idle && w_gnt_1;

  assign Address     = r_addr;
  assign Data_in     = r_wdata;
  assign EN          = r_en;
  assign WR          = r_wr_out;
  assign rsp_valid_0 = r_rsp_valid_0;
  assign rsp_valid_1 = r_rsp_valid_1;
  assign rsp_err_0   = r_rsp_err_0;
  assign rsp_err_1   = r_rsp_err_1;
  assign rsp_rdata_0 = r_rsp_rdata_0;
  assign rsp_rdata_1 = r_rsp_rdata_1;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx  = r_state;
    w_last_nx   = r_last;
    w_owner_nx  = r_owner;
    w_wr_nx     = r_wr;
    w_cnt_nx    = r_cnt;
    w_addr_nx   = r_addr;
    w_wdata_nx  = r_wdata;
    w_en_nx     = 1'b0;
    w_wr_out_nx = 1'b0;
    w_rsp_fire  = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_rdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_0 || w_gnt_1) begin
          w_owner_nx  = w_gnt_1;
          w_last_nx   = w_gnt_1;
          w_wr_nx     = w_gnt_1 ? req_wr_1    : req_wr_0;
          w_addr_nx   = w_gnt_1 ? req_addr_1  : req_addr_0;
          w_wdata_nx  = w_gnt_1 ? req_wdata_1 : req_wdata_0;
          w_en_nx     = 1'b1;
          w_wr_out_nx = w_gnt_1 ? req_wr_1    : req_wr_0;
          w_state_nx  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nx = '0;
        if (r_wr) begin
          w_rsp_fire = 1'b1;
          w_state_nx = S_RESP;
        end else begin
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        // A return in the final WAIT cycle beats the timeout.
        if (valid_out) begin
          w_rsp_fire  = 1'b1;
          w_rsp_rdata = Data_out;
          w_state_nx  = S_RESP;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_rsp_fire = 1'b1;
          w_rsp_err  = 1'b1;
          w_state_nx = S_RESP;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last        <= 1'b1;
      r_owner       <= 1'b0;
      r_wr          <= 1'b0;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_en          <= 1'b0;
      r_wr_out      <= 1'b0;
      r_rsp_valid_0 <= 1'b0;
      r_rsp_valid_1 <= 1'b0;
      r_rsp_err_0   <= 1'b0;
      r_rsp_err_1   <= 1'b0;
      r_rsp_rdata_0 <= '0;
      r_rsp_rdata_1 <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_last        <= w_last_nx;
      r_owner       <= w_owner_nx;
      r_wr          <= w_wr_nx;
      r_cnt         <= w_cnt_nx;
      r_addr        <= w_addr_nx;
      r_wdata       <= w_wdata_nx;
      r_en          <= w_en_nx;
      r_wr_out      <= w_wr_out_nx;
      r_rsp_valid_0 <= w_rsp_fire && !r_owner;
      r_rsp_valid_1 <= w_rsp_fire && r_owner;
      r_rsp_err_0   <= w_rsp_fire && !r_owner && w_rsp_err;
      r_rsp_err_1   <= w_rsp_fire && r_owner && w_rsp_err;
      r_rsp_rdata_0 <= (w_rsp_fire && !r_owner) ? w_rsp_rdata : '0;
      r_rsp_rdata_1 <= (w_rsp_fire && r_owner) ? w_rsp_rdata : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed scenarios plus randomized
// transactions against a transaction-level model of arbitration, memory and timing.
module tb_mem_access_arbiter;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic          req_wr_0, req_wr_1;
  logic [AW-1:0] req_addr_0, req_addr_1;
  logic [DW-1:0] req_wdata_0, req_wdata_1;
  logic          rsp_valid_0, rsp_valid_1, rsp_err_0, rsp_err_1;
  logic [DW-1:0] rsp_rdata_0, rsp_rdata_1;
  logic [AW-1:0] Address;
  logic [DW-1:0] Data_in, Data_out;
  logic          EN, WR, valid_out;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] mem [16];
  int            model_last;

  always #5 clk = ~clk;

  mem_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_wr_0(req_wr_0), .req_wr_1(req_wr_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_rdata_0(rsp_rdata_0), .rsp_rdata_1(rsp_rdata_1),
    .rsp_err_0(rsp_err_0), .rsp_err_1(rsp_err_1),
    .Address(Address), .Data_in(Data_in), .EN(EN), .WR(WR),
    .Data_out(Data_out), .valid_out(valid_out)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Round-robin rule: on a tie the requester not granted last wins.
  function automatic int exp_winner(input bit v0, input bit v1);
    if (v0 && v1) return (model_last == 1) ? 0 : 1;
    return v0 ? 0 : 1;
  endfunction

  // Wait (bounded) for the accepting cycle; returns just after the handshake edge.
  task automatic handshake(input int want, output bit ok, output int waited);
    bit done;
    int got;
    done = 0; ok = 0; waited = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready_0 === 1'b1 && req_ready_1 === 1'b1) begin
        n_err++;
        $display("FAIL ready_exclusive: ready0=%b ready1=%b, required at most one high", req_ready_0, req_ready_1);
      end
      if ((req_valid_0 && req_ready_0 === 1'b1) || (req_valid_1 && req_ready_1 === 1'b1)) begin
        got = (req_ready_1 === 1'b1) ? 1 : 0;
        n_cmp++;
        if (got != want) begin
          n_err++;
          $display("FAIL grant: got requester %0d, required %0d", got, want);
        end
        model_last = want; ok = 1; done = 1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL handshake_timeout: no req_ready within 20 cycles, required requester %0d", want);
    end
  endtask

  // Runs a transaction from the ISSUE cycle to the end of RESP. dly = WAIT cycle index
  // carrying valid_out (>= TO means never); glitch drives valid_out during ISSUE.
  task automatic complete(input int p, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int dly, input bit glitch);
    logic [DW-1:0] exp_d, rd_p, rd_o;
    logic          rv_p, re_p, rv_o, re_o;
    bit            terr;
    valid_out = glitch;
    Data_out  = $urandom;
    @(negedge clk);
    n_cmp++;
    if ({EN, WR, Address} !== {1'b1, wr, a}) begin
      n_err++;
      $display("FAIL issue_cycle: EN/WR/Address=%b/%b/%h, required 1/%b/%h", EN, WR, Address, wr, a);
    end
    if (wr) begin
      n_cmp++;
      if (Data_in !== wd) begin
        n_err++;
        $display("FAIL issue_wdata: Data_in=%h, required %h", Data_in, wd);
      end
    end
    n_cmp++;
    if ({rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1} !== 4'b0) begin
      n_err++;
      $display("FAIL issue_quiet: rsp_valid=%b%b ready=%b%b, required all 0", rsp_valid_1, rsp_valid_0, req_ready_1, req_ready_0);
    end
    exp_d = mem[a];
    terr  = !wr && (dly >= int'(TO));
    if (wr) mem[a] = wd;
    if (!wr) begin
      for (int c = 0; c < int'(TO); c++) begin
        tick();
        valid_out = (c == dly);
        Data_out  = (c == dly) ? exp_d : DW'($urandom);
        @(negedge clk);
        n_cmp++;
        if ({EN, rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1} !== 5'b0) begin
          n_err++;
          $display("FAIL wait_quiet: cycle %0d EN=%b rsp_valid=%b%b ready=%b%b, required all 0", c, EN, rsp_valid_1, rsp_valid_0, req_ready_1, req_ready_0);
        end
        if (c == dly) break;
      end
    end
    tick();
    valid_out = 1'b0;
    Data_out  = $urandom;
    @(negedge clk);
    rv_p = p ? rsp_valid_1 : rsp_valid_0;
    re_p = p ? rsp_err_1   : rsp_err_0;
    rd_p = p ? rsp_rdata_1 : rsp_rdata_0;
    rv_o = p ? rsp_valid_0 : rsp_valid_1;
    re_o = p ? rsp_err_0   : rsp_err_1;
    rd_o = p ? rsp_rdata_0 : rsp_rdata_1;
    n_cmp++;
    if (rv_p !== 1'b1) begin
      n_err++;
      $display("FAIL rsp_valid: requester %0d rsp_valid=%b, required 1", p, rv_p);
    end
    n_cmp++;
    if (re_p !== terr) begin
      n_err++;
      $display("FAIL rsp_err: requester %0d rsp_err=%b, required %b", p, re_p, terr);
    end
    n_cmp++;
    if (rd_p !== ((wr || terr) ? '0 : exp_d)) begin
      n_err++;
      $display("FAIL rsp_rdata: requester %0d rsp_rdata=%h, required %h", p, rd_p, (wr || terr) ? '0 : exp_d);
    end
    n_cmp++;
    if ({rv_o, re_o, rd_o, EN} !== '0) begin
      n_err++;
      $display("FAIL rsp_other: other valid/err/rdata=%b/%b/%h EN=%b, required all 0", rv_o, re_o, rd_o, EN);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    req_wr_0 = 1'b1; req_addr_0 = 4'h1; req_wdata_0 = 32'h0BAD_F00D;
    req_wr_1 = 1'b1; req_addr_1 = 4'h2; req_wdata_1 = 32'h1234_5678;
    valid_out = 1'b0; Data_out = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_err_0, rsp_err_1,
           rsp_rdata_0, rsp_rdata_1, EN, WR, Address, Data_in} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: ready=%b%b rsp_valid=%b%b EN=%b WR=%b Address=%h Data_in=%h, required all 0",
                 req_ready_1, req_ready_0, rsp_valid_1, rsp_valid_0, EN, WR, Address, Data_in);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = 1;
    begin
      bit ok; int wt;
      handshake(exp_winner(1, 1), ok, wt);
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      n_cmp++;
      if (wt != 0) begin
        n_err++;
        $display("FAIL reset_first_accept: waited %0d cycles, required 0", wt);
      end
      if (ok) complete(0, 1'b1, 4'h1, 32'h0BAD_F00D, 0, 1'b0);
    end
  endtask

  task automatic test_write_read();
    bit ok; int wt;
    req_wr_0 = 1'b1; req_addr_0 = 4'h3; req_wdata_0 = 32'hDEAD_BEEF; req_valid_0 = 1'b1;
    handshake(exp_winner(1, 0), ok, wt);
    req_valid_0 = 1'b0;
    if (ok) complete(0, 1'b1, 4'h3, 32'hDEAD_BEEF, 0, 1'b0);
    req_wr_1 = 1'b0; req_addr_1 = 4'h3; req_valid_1 = 1'b1;
    handshake(exp_winner(0, 1), ok, wt);
    req_valid_1 = 1'b0;
    if (ok) complete(1, 1'b0, 4'h3, '0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    bit ok; int wt;
    for (int k = 0; k < 3; k++) begin
      req_wr_0 = 1'b0; req_addr_0 = 4'h3; req_valid_0 = 1'b1;
      handshake(0, ok, wt);
      req_valid_0 = 1'b0;
      // never returns / returns in the last WAIT cycle / never returns but glitch during ISSUE
      if (ok) complete(0, 1'b0, 4'h3, '0, (k == 1) ? int'(TO) - 1 : int'(TO), k == 2);
    end
  endtask

  task automatic test_round_robin();
    bit ok; int wt, w;
    rst = 1'b1; tick(); rst = 1'b0; model_last = 1;
    req_wr_0 = 1'b1; req_wr_1 = 1'b1;
    req_addr_0 = AW'($urandom); req_addr_1 = AW'($urandom);
    req_wdata_0 = $urandom; req_wdata_1 = $urandom;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = exp_winner(1, 1);
      handshake(w, ok, wt);
      if (k > 0) begin
        n_cmp++;
        if (wt != 0) begin
          n_err++;
          $display("FAIL back_to_back: accept %0d waited %0d extra cycles, required 0", k, wt);
        end
      end
      if (!ok) break;
      complete(w, 1'b1, w ? req_addr_1 : req_addr_0, w ? req_wdata_1 : req_wdata_0, 0, 1'b0);
      if (w == 1) begin req_addr_1 = AW'($urandom); req_wdata_1 = $urandom; end
      else        begin req_addr_0 = AW'($urandom); req_wdata_0 = $urandom; end
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    bit ok; int wt;
    req_wr_1 = 1'b0; req_addr_1 = 4'h5; req_valid_1 = 1'b1;
    handshake(exp_winner(0, 1), ok, wt);
    req_valid_1 = 1'b0;
    valid_out = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_last = 1;
    for (int i = 0; i < int'(TO) + 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid_0, rsp_valid_1, EN} !== 3'b0) begin
        n_err++;
        $display("FAIL reset_drop: cycle %0d rsp_valid=%b%b EN=%b, required all 0", i, rsp_valid_1, rsp_valid_0, EN);
      end
      tick();
    end
    req_wr_0 = 1'b1; req_addr_0 = 4'h6; req_wdata_0 = 32'hCAFE_0006; req_valid_0 = 1'b1;
    req_wr_1 = 1'b1; req_addr_1 = 4'h7; req_wdata_1 = 32'hCAFE_0007; req_valid_1 = 1'b1;
    handshake(exp_winner(1, 1), ok, wt);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    if (ok) complete(0, 1'b1, 4'h6, 32'hCAFE_0006, 0, 1'b0);
  endtask

  task automatic test_random();
    bit ok, gl; int wt, m, w, dly;
    for (int k = 0; k < 40; k++) begin
      req_wr_0 = 1'($urandom); req_addr_0 = AW'($urandom); req_wdata_0 = $urandom;
      req_wr_1 = 1'($urandom); req_addr_1 = AW'($urandom); req_wdata_1 = $urandom;
      m = int'($urandom_range(1, 3));
      req_valid_0 = m[0]; req_valid_1 = m[1];
      w = exp_winner(m[0], m[1]);
      handshake(w, ok, wt);
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      dly = int'($urandom_range(0, TO + 2));
      gl  = 1'($urandom);
      if (ok) complete(w, w ? req_wr_1 : req_wr_0, w ? req_addr_1 : req_addr_0,
                       w ? req_wdata_1 : req_wdata_0, dly, gl);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    model_last = 1;
    test_reset();
    test_write_read();
    test_timeout();
    test_round_robin();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
